// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the register-file writeback slice.
//   REG_ADDR_W / REG_DATA_W : default register address / data widths
//   REG_ZERO                : address of the hard-wired zero register
//   wb_pri_e                : writeback arbitration priority state
package rf_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [0:0] {
    LD_PRI  = 1'b0,
    ALU_PRI = 1'b1
  } wb_pri_e;

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: bundle of all non-clock signals of rf_wb_arbiter.
//   ALU request   : alu_valid, alu_rd, alu_data  -> alu_ready
//   Load return   : ld_valid, ld_rd, ld_data     -> ld_ready
//   Load issue    : issue_ld, issue_rd
//   Decode query  : dec_rs1, dec_rs2             -> stall
//   RF write port : we3, ad3, wd3
//   Bypass (only with RF_WB_BYPASS_EN defined): byp1_hit, byp2_hit, byp_data
// modport master = pipeline side, modport slave = arbiter side.
interface rf_wb_arbiter_if
  import rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = REG_DATA_W
);

  logic              alu_valid;
  logic              alu_ready;
  logic [ADDR_W-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              ld_valid;
  logic              ld_ready;
  logic [ADDR_W-1:0] ld_rd;
  logic [DATA_W-1:0] ld_data;
  logic              issue_ld;
  logic [ADDR_W-1:0] issue_rd;
  logic [ADDR_W-1:0] dec_rs1;
  logic [ADDR_W-1:0] dec_rs2;
  logic              stall;
  logic              we3;
  logic [ADDR_W-1:0] ad3;
  logic [DATA_W-1:0] wd3;
`ifdef RF_WB_BYPASS_EN
  logic              byp1_hit;
  logic              byp2_hit;
  logic [DATA_W-1:0] byp_data;

  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_ld, issue_rd, dec_rs1, dec_rs2,
    input  alu_ready, ld_ready, stall, we3, ad3, wd3,
           byp1_hit, byp2_hit, byp_data
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_ld, issue_rd, dec_rs1, dec_rs2,
    output alu_ready, ld_ready, stall, we3, ad3, wd3,
           byp1_hit, byp2_hit, byp_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_ld, issue_rd, dec_rs1, dec_rs2,
    input  alu_ready, ld_ready, stall, we3, ad3, wd3
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_valid, ld_rd, ld_data,
           issue_ld, issue_rd, dec_rs1, dec_rs2,
    output alu_ready, ld_ready, stall, we3, ad3, wd3
  );
`endif

endinterface

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one pending bit per register for loads in flight.
//   clk, rst_n     : clock, async active-low reset (clears all pending bits)
//   set_en, set_rd : a load to set_rd leaves decode (x0 never marked)
//   clr_en, clr_rd : load data for clr_rd accepted for writeback
//   rs1, rs2       : decode source registers
//   stall          : combinational load-use hazard flag
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_rd,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              stall
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_RD = '0;

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next pending vector: clear first, then set, so a new load to the same
  // register in the same cycle stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_rd] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (set_en && (set_rd != ZERO_RD)) begin
      pending_d[set_rd] = 1'b1;
    end else begin
      pending_d[ZERO_RD] = 1'b0;
    end
  end

  // Pending vector register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Hazard check against current state only; x0 never stalls.
  always_comb begin
    stall = (pending_q[rs1] && (rs1 != ZERO_RD)) ||
            (pending_q[rs2] && (rs2 != ZERO_RD));
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port between the ALU result
// path and the load-return path, and tracks outstanding loads for decode.
//   clk, rst_n : clock (rising edge), async active-low reset
//   bus        : rf_wb_arbiter_if.slave (requests, ready, stall, we3/ad3/wd3)
// Optional: define RF_WB_BYPASS_EN to add byp1_hit/byp2_hit/byp_data, which
// expose the write of the current cycle to decode.
// Loads normally win; after MAX_WAIT consecutive refusals the ALU gets one
// cycle of priority so it cannot starve.
module rf_wb_arbiter
  import rf_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int MAX_WAIT = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  rf_wb_arbiter_if.slave  bus
);

  localparam logic [ADDR_W-1:0] ZERO_RD    = '0;
  localparam logic [3:0]        MAX_WAIT_C = 4'(MAX_WAIT);

  wb_pri_e           state_q;
  wb_pri_e           state_d;
  logic [3:0]        wait_cnt_q;
  logic [3:0]        wait_cnt_d;
  logic              we3_q;
  logic              we3_d;
  logic [ADDR_W-1:0] ad3_q;
  logic [ADDR_W-1:0] ad3_d;
  logic [DATA_W-1:0] wd3_q;
  logic [DATA_W-1:0] wd3_d;
  logic              grant_ld;
  logic              grant_alu;

  // Arbitration: grant selection, starvation counter and priority state.
  always_comb begin
    grant_ld   = 1'b0;
    grant_alu  = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      LD_PRI: begin
        if (bus.ld_valid) begin
          grant_ld = 1'b1;
        end else if (bus.alu_valid) begin
          grant_alu = 1'b1;
        end else begin
          grant_ld = 1'b0;
        end
        if (grant_alu) begin
          wait_cnt_d = 4'd0;
        end else if (bus.alu_valid) begin
          // ALU refused this cycle.
          if ((wait_cnt_q + 4'd1) >= MAX_WAIT_C) begin
            state_d    = ALU_PRI;
            wait_cnt_d = 4'd0;
          end else begin
            wait_cnt_d = wait_cnt_q + 4'd1;
          end
        end else begin
          wait_cnt_d = wait_cnt_q;
        end
      end
      ALU_PRI: begin
        if (bus.alu_valid) begin
          grant_alu = 1'b1;
        end else if (bus.ld_valid) begin
          grant_ld = 1'b1;
        end else begin
          grant_alu = 1'b0;
        end
        // Priority lasts exactly one cycle.
        state_d    = LD_PRI;
        wait_cnt_d = 4'd0;
      end
      default: begin
        state_d    = LD_PRI;
        wait_cnt_d = 4'd0;
      end
    endcase
  end

  // Write-port next values; x0 is accepted but never written.
  always_comb begin
    we3_d = 1'b0;
    ad3_d = ad3_q;
    wd3_d = wd3_q;
    if (grant_ld) begin
      we3_d = (bus.ld_rd != ZERO_RD);
      ad3_d = bus.ld_rd;
      wd3_d = bus.ld_data;
    end else if (grant_alu) begin
      we3_d = (bus.alu_rd != ZERO_RD);
      ad3_d = bus.alu_rd;
      wd3_d = bus.alu_data;
    end else begin
      we3_d = 1'b0;
    end
  end

  // Arbiter state and registered write-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= LD_PRI;
      wait_cnt_q <= 4'd0;
      we3_q      <= 1'b0;
      ad3_q      <= '0;
      wd3_q      <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      we3_q      <= we3_d;
      ad3_q      <= ad3_d;
      wd3_q      <= wd3_d;
    end
  end

  assign bus.ld_ready  = grant_ld;
  assign bus.alu_ready = grant_alu;
  assign bus.we3       = we3_q;
  assign bus.ad3       = ad3_q;
  assign bus.wd3       = wd3_q;

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk    (clk),
    .rst_n  (rst_n),
    .set_en (bus.issue_ld),
    .set_rd (bus.issue_rd),
    .clr_en (grant_ld),
    .clr_rd (bus.ld_rd),
    .rs1    (bus.dec_rs1),
    .rs2    (bus.dec_rs2),
    .stall  (bus.stall)
  );

`ifdef RF_WB_BYPASS_EN
  // The register file reads before the write edge, so decode needs the
  // value currently on the write port.
  assign bus.byp1_hit = we3_q && (ad3_q != ZERO_RD) && (ad3_q == bus.dec_rs1);
  assign bus.byp2_hit = we3_q && (ad3_q != ZERO_RD) && (ad3_q == bus.dec_rs2);
  assign bus.byp_data = wd3_q;
`endif

endmodule
